// File: rtl/decode_fetch_ctrl.sv
// Decode-stage front end: fetches words into a byte buffer, presents a byte window, retires lengths, handles redirects.
// Optional statistics counters (stat_retired, stat_starved) are enabled by defining DECODE_FETCH_STATS_EN.
module decode_fetch_ctrl #(
    parameter int WIN_BYTES = 9,
    parameter int BUF_BYTES = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    output logic                   fetch_valid,
    input  logic                   fetch_ready,
    output logic [31:0]            fetch_addr,
    input  logic                   fetch_rvalid,
    input  logic [31:0]            fetch_rdata,
    output logic [8*WIN_BYTES-1:0] window,
    output logic                   window_valid,
    output logic [31:0]            window_pc,
    input  logic                   consume_valid,
    input  logic [3:0]             consume_len,
    output logic                   err
`ifdef DECODE_FETCH_STATS_EN
    ,
    output logic [31:0]            stat_retired,
    output logic [31:0]            stat_starved
`endif
);

    localparam int CW = $clog2(BUF_BYTES + 1);
    localparam int IW = $clog2(BUF_BYTES);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [31:0]     pc_reg, pc_next;
    logic [31:0]     fetch_addr_reg, fetch_addr_next;
    logic [31:0]     restart_reg, restart_next;
    logic            pend_reg, pend_next;
    logic            stale_reg, stale_next;
    logic            inflight_reg, inflight_next;
    logic            drop_reg, drop_next;
    logic            first_reg, first_next;
    logic [1:0]      off_reg, off_next;
    logic [7:0]      fifo_reg [BUF_BYTES];
    logic [7:0]      rbyte [4];

    logic            accept;
    logic            cons_act;
    logic            cons_legal;
    logic            do_shift;
    logic            fill;
    logic [1:0]      skip;
    logic [CW-1:0]   shift_len;
    logic [CW-1:0]   post_cnt;
    logic [CW-1:0]   appended;

    genvar gi;

    assign window_valid = (state_reg == RUN) && (count_reg >= CW'(WIN_BYTES));
    // A pending request is held even outside RUN so its address stays stable until accepted.
    assign fetch_valid  = pend_reg ||
                          ((state_reg == RUN) && !inflight_reg && (count_reg <= CW'(BUF_BYTES - 4)));
    assign fetch_addr   = fetch_addr_reg;
    assign window_pc    = pc_reg;
    assign err          = (state_reg == HALT);

    assign accept     = fetch_valid && fetch_ready;
    assign cons_act   = consume_valid && window_valid;
    assign cons_legal = (consume_len != 4'd0) && ({28'd0, consume_len} <= 32'(WIN_BYTES));
    assign do_shift   = !redirect && cons_act && cons_legal;
    assign fill       = !redirect && fetch_rvalid && inflight_reg && !drop_reg;
    assign skip       = first_reg ? off_reg : 2'd0;
    assign shift_len  = do_shift ? CW'(consume_len) : '0;
    assign post_cnt   = count_reg - shift_len;
    assign appended   = fill ? (CW'(4) - CW'(skip)) : '0;
    assign count_next = redirect ? '0 : (post_cnt + appended);

    generate
        for (gi = 0; gi < 4; gi++) begin : g_rbyte
            assign rbyte[gi] = fetch_rdata[8*gi +: 8];
        end
        for (gi = 0; gi < WIN_BYTES; gi++) begin : g_win
            assign window[8*gi +: 8] = fifo_reg[gi];
        end
    endgenerate

    // Each buffer byte takes the shifted byte, then is overwritten by an appended byte if it lands here.
    // Bytes at or above count are always zero, so the window needs no masking.
    generate
        for (gi = 0; gi < BUF_BYTES; gi++) begin : g_byte
            localparam logic [CW:0] GI = (CW+1)'(gi);
            logic [CW:0] src;
            logic [CW:0] rel;
            logic [CW:0] k;
            logic [7:0]  byte_next;

            always_comb begin
                byte_next = '0;
                src       = GI + {1'b0, shift_len};
                rel       = GI - {1'b0, post_cnt};
                k         = rel + {{(CW-1){1'b0}}, skip};
                if (!redirect) begin
                    if (src < (CW+1)'(BUF_BYTES)) begin
                        byte_next = fifo_reg[src[IW-1:0]];
                    end
                    if (fill && (GI >= {1'b0, post_cnt}) && (k < (CW+1)'(4))) begin
                        byte_next = rbyte[k[1:0]];
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    fifo_reg[gi] <= '0;
                end else begin
                    fifo_reg[gi] <= byte_next;
                end
            end
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        fetch_addr_next = fetch_addr_reg;
        restart_next    = restart_reg;
        pend_next       = pend_reg;
        stale_next      = stale_reg;
        inflight_next   = inflight_reg;
        drop_next       = drop_reg;
        first_next      = first_reg;
        off_next        = off_reg;
        if (redirect) begin
            state_next    = RUN;
            pc_next       = redirect_pc;
            first_next    = 1'b1;
            off_next      = redirect_pc[1:0];
            inflight_next = accept || (inflight_reg && !fetch_rvalid);
            drop_next     = accept || (inflight_reg && !fetch_rvalid);
            if (fetch_valid && !fetch_ready) begin
                // Old-address request keeps its address; the new stream starts once it is accepted.
                pend_next    = 1'b1;
                stale_next   = 1'b1;
                restart_next = {redirect_pc[31:2], 2'b00};
            end else begin
                pend_next       = 1'b0;
                stale_next      = 1'b0;
                fetch_addr_next = {redirect_pc[31:2], 2'b00};
            end
        end else begin
            if (cons_act && !cons_legal) begin
                state_next = HALT;
            end
            if (do_shift) begin
                pc_next = pc_reg + {28'd0, consume_len};
            end
            if (fetch_rvalid && inflight_reg) begin
                inflight_next = 1'b0;
                drop_next     = 1'b0;
            end
            if (fill) begin
                first_next = 1'b0;
            end
            if (accept) begin
                inflight_next = 1'b1;
                pend_next     = 1'b0;
                if (stale_reg) begin
                    drop_next       = 1'b1;
                    stale_next      = 1'b0;
                    fetch_addr_next = restart_reg;
                end else begin
                    fetch_addr_next = fetch_addr_reg + 32'd4;
                end
            end else if (fetch_valid) begin
                pend_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            pc_reg         <= '0;
            fetch_addr_reg <= '0;
            restart_reg    <= '0;
            pend_reg       <= 1'b0;
            stale_reg      <= 1'b0;
            inflight_reg   <= 1'b0;
            drop_reg       <= 1'b0;
            first_reg      <= 1'b0;
            off_reg        <= 2'd0;
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            pc_reg         <= pc_next;
            fetch_addr_reg <= fetch_addr_next;
            restart_reg    <= restart_next;
            pend_reg       <= pend_next;
            stale_reg      <= stale_next;
            inflight_reg   <= inflight_next;
            drop_reg       <= drop_next;
            first_reg      <= first_next;
            off_reg        <= off_next;
        end
    end

`ifdef DECODE_FETCH_STATS_EN
    logic [31:0] retired_reg, starved_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_reg <= '0;
            starved_reg <= '0;
        end else if (redirect && (state_reg == IDLE)) begin
            retired_reg <= '0;
            starved_reg <= '0;
        end else begin
            if (do_shift) begin
                retired_reg <= retired_reg + 32'd1;
            end
            if ((state_reg == RUN) && !window_valid) begin
                starved_reg <= starved_reg + 32'd1;
            end
        end
    end

    assign stat_retired = retired_reg;
    assign stat_starved = starved_reg;
`endif

endmodule

// File: tb/tb_decode_fetch_ctrl.sv
// Directed self-checking bench for decode_fetch_ctrl with a one-outstanding memory responder.
module tb_decode_fetch_ctrl;
    localparam int WIN_BYTES = 9;
    localparam int WW        = 8 * WIN_BYTES;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          redirect = 1'b0;
    logic [31:0]   redirect_pc = '0;
    logic          fetch_valid;
    logic          fetch_ready = 1'b1;
    logic [31:0]   fetch_addr;
    logic          fetch_rvalid = 1'b0;
    logic [31:0]   fetch_rdata = '0;
    logic [WW-1:0] window;
    logic          window_valid;
    logic [31:0]   window_pc;
    logic          consume_valid = 1'b0;
    logic [3:0]    consume_len = '0;
    logic          err;
`ifdef DECODE_FETCH_STATS_EN
    logic [31:0]   stat_retired;
    logic [31:0]   stat_starved;
`endif

    int          n_checks = 0;
    int          n_fail = 0;
    int          mem_lat = 1;
    int          q_cnt = 0;
    logic [31:0] q_addr = '0;
    logic [31:0] acc_q [$];

    decode_fetch_ctrl #(.WIN_BYTES(WIN_BYTES), .BUF_BYTES(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .fetch_valid  (fetch_valid),
        .fetch_ready  (fetch_ready),
        .fetch_addr   (fetch_addr),
        .fetch_rvalid (fetch_rvalid),
        .fetch_rdata  (fetch_rdata),
        .window       (window),
        .window_valid (window_valid),
        .window_pc    (window_pc),
        .consume_valid(consume_valid),
        .consume_len  (consume_len),
        .err          (err)
`ifdef DECODE_FETCH_STATS_EN
        ,
        .stat_retired (stat_retired),
        .stat_starved (stat_starved)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]};
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    function automatic logic [WW-1:0] exp_win(input logic [31:0] pc);
        logic [WW-1:0] w;
        for (int i = 0; i < WIN_BYTES; i++) w[8*i +: 8] = mem_byte(pc + 32'(i));
        return w;
    endfunction

    // One clock cycle: record an acceptance, advance, then drive the responder for the new cycle.
    task automatic tick();
        #1;
        if (fetch_valid && fetch_ready) begin
            acc_q.push_back(fetch_addr);
            q_addr = fetch_addr;
            q_cnt  = mem_lat;
        end
        @(posedge clk);
        #1;
        redirect      = 1'b0;
        consume_valid = 1'b0;
        consume_len   = '0;
        fetch_rvalid  = 1'b0;
        if (q_cnt > 0) begin
            q_cnt--;
            if (q_cnt == 0) begin
                fetch_rvalid = 1'b1;
                fetch_rdata  = mem_word(q_addr);
            end
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (window_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        $display("redirect to %08h", pc);
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fetch_valid: got %b want 0", fetch_valid); end
        n_checks++; if (fetch_addr !== 32'd0) begin n_fail++; $display("FAIL reset_fetch_addr: got %08h want 0", fetch_addr); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_checks++; if (window !== '0) begin n_fail++; $display("FAIL reset_window: got %h want 0", window); end
        n_checks++; if (window_pc !== 32'd0) begin n_fail++; $display("FAIL reset_window_pc: got %08h want 0", window_pc); end
        n_checks++; if (window_valid !== 1'b0) begin n_fail++; $display("FAIL reset_window_valid: got %b want 0", window_valid); end
        rst_n = 1'b1;
        repeat (3) tick();
        n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL idle_no_fetch: got %b want 0", fetch_valid); end
        n_checks++; if (acc_q.size() != 0) begin n_fail++; $display("FAIL idle_no_accept: got %0d want 0", acc_q.size()); end
    endtask

    task automatic test_aligned_fetch();
        bit ok;
        logic [31:0] want;
        acc_q.delete();
        do_redirect(32'h1000);
        n_checks++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL first_fetch_valid: got %b want 1", fetch_valid); end
        n_checks++; if (fetch_addr !== 32'h1000) begin n_fail++; $display("FAIL first_fetch_addr: got %08h want 00001000", fetch_addr); end
        n_checks++; if (window_pc !== 32'h1000) begin n_fail++; $display("FAIL redirect_pc: got %08h want 00001000", window_pc); end
        n_checks++; if (window_valid !== 1'b0) begin n_fail++; $display("FAIL redirect_window_valid: got %b want 0", window_valid); end
        wait_valid(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL aligned_timeout: window_valid got 0 want 1"); end
        n_checks++;
        if (acc_q.size() < 3) begin
            n_fail++; $display("FAIL aligned_req_count: got %0d want >=3", acc_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                want = 32'h1000 + 32'(4 * i);
                $display("fetch request %0d addr %08h", i, acc_q[i]);
                n_checks++; if (acc_q[i] !== want) begin n_fail++; $display("FAIL aligned_req_addr%0d: got %08h want %08h", i, acc_q[i], want); end
            end
        end
        n_checks++; if (window_pc !== 32'h1000) begin n_fail++; $display("FAIL aligned_pc: got %08h want 00001000", window_pc); end
        n_checks++; if (window[7:0] !== mem_byte(32'h1000)) begin n_fail++; $display("FAIL aligned_byte0: got %02h want %02h", window[7:0], mem_byte(32'h1000)); end
        n_checks++; if (window !== exp_win(32'h1000)) begin n_fail++; $display("FAIL aligned_window: got %h want %h", window, exp_win(32'h1000)); end
    endtask

    task automatic test_consume_loop();
        bit ok;
        logic [3:0]  lens [4];
        logic [31:0] pc;
        lens = '{4'd1, 4'd5, 4'd9, 4'd2};
        pc   = 32'h1000;
        for (int i = 0; i < 4; i++) begin
            wait_valid(ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL consume_timeout%0d: window_valid got 0 want 1", i); end
            n_checks++; if (window_pc !== pc) begin n_fail++; $display("FAIL consume_pc%0d: got %08h want %08h", i, window_pc, pc); end
            n_checks++; if (window !== exp_win(pc)) begin n_fail++; $display("FAIL consume_window%0d: got %h want %h", i, window, exp_win(pc)); end
            consume_valid = 1'b1;
            consume_len   = lens[i];
            $display("consume len %0d at pc %08h", lens[i], pc);
            tick();
            pc = pc + {28'd0, lens[i]};
        end
        wait_valid(ok);
        n_checks++; if (window_pc !== 32'h1011) begin n_fail++; $display("FAIL consume_final_pc: got %08h want 00001011", window_pc); end
        n_checks++; if (window !== exp_win(32'h1011)) begin n_fail++; $display("FAIL consume_final_window: got %h want %h", window, exp_win(32'h1011)); end
    endtask

    task automatic test_unaligned_redirect();
        bit ok;
        do_redirect(32'h2003);
        acc_q.delete();
        wait_valid(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL unaligned_timeout: window_valid got 0 want 1"); end
        n_checks++;
        if (acc_q.size() == 0) begin
            n_fail++; $display("FAIL unaligned_req: got no request want 00002000");
        end else if (acc_q[0] !== 32'h2000) begin
            n_fail++; $display("FAIL unaligned_req: got %08h want 00002000", acc_q[0]);
        end
        n_checks++; if (window_pc !== 32'h2003) begin n_fail++; $display("FAIL unaligned_pc: got %08h want 00002003", window_pc); end
        n_checks++; if (window[7:0] !== mem_byte(32'h2003)) begin n_fail++; $display("FAIL unaligned_byte0: got %02h want %02h", window[7:0], mem_byte(32'h2003)); end
        n_checks++; if (window !== exp_win(32'h2003)) begin n_fail++; $display("FAIL unaligned_window: got %h want %h", window, exp_win(32'h2003)); end
    endtask

    task automatic test_redirect_inflight();
        bit ok;
        mem_lat = 3;
        do_redirect(32'h3000);
        for (int i = 0; i < 20; i++) begin
            if (fetch_valid === 1'b1) break;
            tick();
        end
        n_checks++; if (fetch_addr !== 32'h3000 || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL inflight_setup: got valid %b addr %08h want 1 00003000", fetch_valid, fetch_addr); end
        tick();
        do_redirect(32'h4001);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (window_valid === 1'b1) begin ok = 1'b1; break; end
            n_checks++;
            if (window[7:0] !== 8'h00 && window[7:0] !== mem_byte(32'h4001)) begin
                n_fail++; $display("FAIL stale_byte: got %02h want 00 or %02h", window[7:0], mem_byte(32'h4001));
            end
            tick();
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL inflight_timeout: window_valid got 0 want 1"); end
        n_checks++; if (window_pc !== 32'h4001) begin n_fail++; $display("FAIL inflight_pc: got %08h want 00004001", window_pc); end
        n_checks++; if (window !== exp_win(32'h4001)) begin n_fail++; $display("FAIL inflight_window: got %h want %h", window, exp_win(32'h4001)); end
        mem_lat = 1;
    endtask

    task automatic test_illegal_consume();
        bit ok;
        logic [3:0]  bad [2];
        logic [31:0] tgt [2];
        bad = '{4'd0, 4'd10};
        tgt = '{32'h1000, 32'h6000};
        for (int i = 0; i < 2; i++) begin
            wait_valid(ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL illegal_pre_timeout%0d: window_valid got 0 want 1", i); end
            consume_valid = 1'b1;
            consume_len   = bad[i];
            $display("illegal consume len %0d", bad[i]);
            tick();
            n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL illegal_err%0d: got %b want 1", i, err); end
            n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL illegal_fetch%0d: got %b want 0", i, fetch_valid); end
            n_checks++; if (window_valid !== 1'b0) begin n_fail++; $display("FAIL illegal_wvalid%0d: got %b want 0", i, window_valid); end
            repeat (2) tick();
            n_checks++; if (err !== 1'b1 || fetch_valid !== 1'b0) begin n_fail++; $display("FAIL halt_sticky%0d: got err %b fetch %b want 1 0", i, err, fetch_valid); end
            do_redirect(tgt[i]);
            n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear%0d: got %b want 0", i, err); end
            wait_valid(ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL resume_timeout%0d: window_valid got 0 want 1", i); end
            n_checks++; if (window_pc !== tgt[i]) begin n_fail++; $display("FAIL resume_pc%0d: got %08h want %08h", i, window_pc, tgt[i]); end
            n_checks++; if (window !== exp_win(tgt[i])) begin n_fail++; $display("FAIL resume_window%0d: got %h want %h", i, window, exp_win(tgt[i])); end
        end
    endtask

    task automatic test_same_cycle();
        bit ok;
        logic [WW-1:0] w;
        repeat (10) tick();
        n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL full_buffer_no_fetch: got %b want 0", fetch_valid); end
        do_redirect(32'h5000);
        wait_valid(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL same_timeout: window_valid got 0 want 1"); end
        n_checks++; if (fetch_valid !== 1'b1 || fetch_addr !== 32'h500C) begin n_fail++; $display("FAIL same_issue: got valid %b addr %08h want 1 0000500c", fetch_valid, fetch_addr); end
        tick();
        // Response for 0x500C is on the bus this cycle while count is 12.
        consume_valid = 1'b1;
        consume_len   = 4'd3;
        $display("consume len 3 with fill, rvalid=%b", fetch_rvalid);
        tick();
        n_checks++; if (window_pc !== 32'h5003) begin n_fail++; $display("FAIL same_pc: got %08h want 00005003", window_pc); end
        n_checks++; if (window !== exp_win(32'h5003)) begin n_fail++; $display("FAIL same_window: got %h want %h", window, exp_win(32'h5003)); end
        consume_valid = 1'b1;
        consume_len   = 4'd4;
        tick();
        n_checks++; if (window_valid !== 1'b1) begin n_fail++; $display("FAIL count9_valid: got %b want 1", window_valid); end
        n_checks++; if (window_pc !== 32'h5007) begin n_fail++; $display("FAIL append_pc: got %08h want 00005007", window_pc); end
        n_checks++; if (window !== exp_win(32'h5007)) begin n_fail++; $display("FAIL append_window: got %h want %h", window, exp_win(32'h5007)); end
        consume_valid = 1'b1;
        consume_len   = 4'd1;
        tick();
        w = exp_win(32'h5008);
        n_checks++; if (window_valid !== 1'b0) begin n_fail++; $display("FAIL count8_valid: got %b want 0", window_valid); end
        n_checks++; if (window[WW-1 -: 8] !== 8'h00) begin n_fail++; $display("FAIL above_count_zero: got %02h want 00", window[WW-1 -: 8]); end
        n_checks++; if (window[WW-9:0] !== w[WW-9:0]) begin n_fail++; $display("FAIL count8_bytes: got %h want %h", window[WW-9:0], w[WW-9:0]); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_aligned_fetch();
        test_consume_loop();
        test_unaligned_redirect();
        test_redirect_inflight();
        test_illegal_consume();
        test_same_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/decode_fetch_ctrl.md
Name: decode_fetch_ctrl

Overview:
- Front-end sequencer for the decode stage. Fetches 32-bit code words from instruction memory into a byte buffer and presents a little-endian byte window to the decoder.
- Window byte 0 (bits [7:0]) is the first byte of the next instruction.
- Retires decoder-reported instruction lengths and tracks the PC of the window head.
- Handles control-flow redirects, including unaligned targets.

Parameters:
- WIN_BYTES, 9: bytes presented to the decoder; window width is 8*WIN_BYTES.
- BUF_BYTES, 16: byte buffer depth. Must be at least WIN_BYTES+4.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- redirect  in  1  one-cycle pulse: flush the buffer and restart at redirect_pc
- redirect_pc  in  32  new byte PC
- fetch_valid  out  1  fetch request valid
- fetch_ready  in  1  memory accepts the request
- fetch_addr  out  32  word-aligned fetch address (bits [1:0]=0)
- fetch_rvalid  in  1  response data valid
- fetch_rdata  in  32  response word; byte 0 in [7:0] is the lowest address
- window  out  8*WIN_BYTES  instruction bytes; byte i at [8i+7:8i]
- window_valid  out  1  buffer holds at least WIN_BYTES bytes and state is RUN
- window_pc  out  32  PC of window byte 0
- consume_valid  in  1  decoder retires an instruction
- consume_len  in  4  instruction length in bytes
- err  out  1  sticky illegal-consume flag

Behaviour:
- Reset values:
  - state=IDLE; count=0; window=0; window_pc=0.
  - fetch_valid=0; fetch_addr=0; err=0.
  - No request in flight; drop flag clear.
- States:
  - IDLE: no fetches. Goes to RUN on redirect.
  - RUN: fetching and issuing.
  - HALT: entered on an illegal consume. err=1, window_valid=0, no new requests. Leaves only on redirect (to RUN, err cleared) or reset.
- Fetch issue:
  - In RUN, raise fetch_valid when there is no request outstanding (neither pending nor in flight) and count <= BUF_BYTES-4.
  - fetch_addr is held stable until fetch_ready.
  - On acceptance, the request becomes in flight and fetch_addr advances by 4.
  - One request outstanding at most. The response may arrive any cycle after acceptance, including the next cycle.
- Fill:
  - A response appends its 4 bytes at buffer offset count; count += 4.
  - For the first response after a redirect, the low off=redirect_pc[1:0] bytes are discarded and 4-off bytes are appended.
  - Appended bytes are visible on window the cycle after fetch_rvalid.
- Consume:
  - Acts only when consume_valid && window_valid.
  - Legal when 1 <= consume_len <= WIN_BYTES. The buffer shifts down by consume_len bytes, count -= consume_len, and window_pc += consume_len (mod 2^32).
  - consume_len=0 or consume_len>WIN_BYTES: no shift, state goes to HALT, err=1 the next cycle.
  - consume_valid while window_valid=0 is ignored.
- Same-cycle consume and fill:
  - The shift is applied first, then the append at the post-shift count.
  - count' = count - len + appended.
- Redirect (highest priority, overrides consume and fill in the same cycle):
  - Next cycle: count=0, window_valid=0, window_pc=redirect_pc.
  - Next fetch address = {redirect_pc[31:2],2'b00}; off=redirect_pc[1:0] is recorded.
  - If a request is in flight, or accepted in the redirect cycle, set the drop flag; the next response is discarded and the flag clears.
  - A request still pending (fetch_valid high, fetch_ready low) stays at its old address until accepted, then is dropped. The first new-address request issues after that.
  - A redirect in IDLE, RUN or HALT is always honoured.
- Arithmetic:
  - count is $clog2(BUF_BYTES+1) bits and never exceeds BUF_BYTES, guaranteed by the issue rule.
  - Bytes at or above count in the window read as 0.

Optional Feature:
- DECODE_FETCH_STATS_EN defined:
  - Adds output ports stat_retired (32 bits), incremented on each legal consume, and stat_starved (32 bits), incremented each RUN cycle with window_valid=0.
  - Both counters reset to 0, clear on redirect into RUN from IDLE, and wrap at 2^32.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then redirect to pc=0x1000 with memory returning 1 cycle after acceptance:
  - Requests go to 0x1000, 0x1004 and 0x1008.
  - window_valid rises once count>=9; window_pc=0x1000; window[7:0] is the byte at 0x1000.
- Unaligned redirect to 0x2003:
  - First request to 0x2000; only byte 3 of that word is kept.
  - window[7:0] is the byte at 0x2003; window_pc=0x2003.
- Consume loop with lengths 1,5,9,2:
  - window_pc steps 0x1000→0x1001→0x1006→0x100F→0x1011.
  - Window contents match memory at each step; count never exceeds 16.
- Redirect while a request is in flight:
  - The stale response is dropped; no stale byte ever appears in window.
  - window_pc equals the new target on the first valid window.
- consume_len=0 and, separately, consume_len=10:
  - err=1 the next cycle, fetch_valid=0, window_valid=0.
  - A later redirect clears err and resumes fetching.
- Same-cycle consume_len=3 and fetch_rvalid with count=12:
  - count becomes 13; bytes are shifted correctly with the new word appended at offset 9.
